// File: rtl/instruction_fetch_queue.sv
// ============================================================================
// Module      : instruction_fetch_queue
// Description : Sequential instruction fetcher with a QDEPTH-entry
//               fall-through prefetch queue and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_queue #(
    parameter int                     PC_WIDTH = 32,
    parameter int                     IWIDTH   = 32,
    parameter int                     QDEPTH   = 4,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
    parameter int                     PC_STEP  = 4
) (
    input  logic                        f_clk,
    input  logic                        f_rst,
    input  logic                        f_i_ce,
    input  logic                        f_i_change_pc,
    input  logic [PC_WIDTH-1:0]         f_i_pc,
    output logic                        f_o_req,
    output logic [PC_WIDTH-1:0]         f_o_addr,
    input  logic                        f_i_ack,
    input  logic [IWIDTH-1:0]           f_i_instr,
    output logic                        f_o_valid,
    output logic [IWIDTH-1:0]           f_o_instr,
    output logic [PC_WIDTH-1:0]         f_o_pc,
    input  logic                        f_i_ready,
    output logic [$clog2(QDEPTH):0]     f_o_count
);

    localparam int                  PW      = $clog2(QDEPTH);
    localparam int                  CW      = PW + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(QDEPTH);
    localparam logic [PC_WIDTH-1:0] STEP_C  = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;

    logic [IWIDTH-1:0]      instr_mem [QDEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [QDEPTH];

    logic                   w_push;
    logic                   w_pop;
    logic                   w_room;
    logic [CW-1:0]          w_count_next;
    logic [PC_WIDTH-1:0]    w_pc_inc;

    assign w_push       = (state_q == S_REQ) & f_i_ack & ~f_i_change_pc;
    assign w_pop        = f_o_valid & f_i_ready;
    assign w_count_next = count_q + CW'(w_push) - CW'(w_pop);
    // Outstanding request reserves the slot its response will land in.
    assign w_room       = (w_count_next < DEPTH_C);
    assign w_pc_inc     = fetch_pc_q + STEP_C;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        count_d    = w_count_next;
        rd_ptr_d   = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        if (f_i_change_pc) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = f_i_pc;
            case (state_q)
                S_REQ:   state_d = f_i_ack ? S_IDLE : S_DROP;
                S_DROP:  state_d = f_i_ack ? S_IDLE : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (f_i_ce && w_room) begin
                        state_d = S_REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (f_i_ack) begin
                        fetch_pc_d = w_pc_inc;
                        if (f_i_ce && w_room) begin
                            addr_d = w_pc_inc;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (f_i_ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge f_clk) begin
        if (w_push) begin
            instr_mem[wr_ptr_q] <= f_i_instr;
            pc_mem[wr_ptr_q]    <= addr_q;
        end
    end

    assign f_o_req   = (state_q != S_IDLE);
    assign f_o_addr  = addr_q;
    assign f_o_valid = (count_q != '0);
    assign f_o_instr = f_o_valid ? instr_mem[rd_ptr_q] : '0;
    assign f_o_pc    = f_o_valid ? pc_mem[rd_ptr_q]    : '0;
    assign f_o_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ============================================================================
// Module      : tb_instruction_fetch_queue
// Description : Directed vector bench for instruction_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_queue;

    logic        f_clk;
    logic        f_rst;
    logic        f_i_ce;
    logic        f_i_change_pc;
    logic [31:0] f_i_pc;
    logic        f_o_req;
    logic [31:0] f_o_addr;
    logic        f_i_ack;
    logic [31:0] f_i_instr;
    logic        f_o_valid;
    logic [31:0] f_o_instr;
    logic [31:0] f_o_pc;
    logic        f_i_ready;
    logic [2:0]  f_o_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ce;
        logic        chg;
        logic [31:0] tpc;
        logic        ack;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tab [16];

    instruction_fetch_queue #(
        .PC_WIDTH (32),
        .IWIDTH   (32),
        .QDEPTH   (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_i_ce        (f_i_ce),
        .f_i_change_pc (f_i_change_pc),
        .f_i_pc        (f_i_pc),
        .f_o_req       (f_o_req),
        .f_o_addr      (f_o_addr),
        .f_i_ack       (f_i_ack),
        .f_i_instr     (f_i_instr),
        .f_o_valid     (f_o_valid),
        .f_o_instr     (f_o_instr),
        .f_o_pc        (f_o_pc),
        .f_i_ready     (f_i_ready),
        .f_o_count     (f_o_count)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    function automatic vec_t mk(logic ce, logic chg, logic [31:0] tpc, logic ack, logic rdy,
                                logic req, logic [31:0] addr, logic valid, logic [31:0] pc,
                                logic [2:0] cnt);
        vec_t v;
        v.ce = ce; v.chg = chg; v.tpc = tpc; v.ack = ack; v.rdy = rdy;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory returns ~addr, so a queued entry's instruction is always ~pc.
    task automatic check_outs(input string tag, input vec_t v);
        logic [31:0] ei;
        ei = v.valid ? ~v.pc : 32'h0;
        chk({tag, ".req"},   {31'h0, f_o_req},   {31'h0, v.req});
        chk({tag, ".addr"},  f_o_addr,           v.addr);
        chk({tag, ".valid"}, {31'h0, f_o_valid}, {31'h0, v.valid});
        chk({tag, ".pc"},    f_o_pc,             v.pc);
        chk({tag, ".instr"}, f_o_instr,          ei);
        chk({tag, ".count"}, {29'h0, f_o_count}, {29'h0, v.cnt});
    endtask

    task automatic step(input string tag, input vec_t v);
        f_i_ce        = v.ce;
        f_i_change_pc = v.chg;
        f_i_pc        = v.tpc;
        f_i_ack       = v.ack;
        f_i_instr     = ~f_o_addr;
        f_i_ready     = v.rdy;
        @(posedge f_clk);
        #1;
        check_outs(tag, v);
    endtask

    task automatic do_reset(input string tag);
        f_rst         = 1'b0;
        f_i_ce        = 1'b0;
        f_i_change_pc = 1'b0;
        f_i_pc        = '0;
        f_i_ack       = 1'b0;
        f_i_instr     = '0;
        f_i_ready     = 1'b0;
        #1;
        check_outs(tag, mk(0,0,0,0,0, 0,32'h0,0,32'h0,3'd0));
        @(negedge f_clk);
        f_rst = 1'b1;
    endtask

    initial begin
        // Fill to depth, then stream with decode ready, then drain with ce low.
        tab[0]  = mk(1,0,0,0,0, 1,32'h00,0,32'h00,3'd0);
        tab[1]  = mk(1,0,0,1,0, 1,32'h04,1,32'h00,3'd1);
        tab[2]  = mk(1,0,0,1,0, 1,32'h08,1,32'h00,3'd2);
        tab[3]  = mk(1,0,0,1,0, 1,32'h0C,1,32'h00,3'd3);
        tab[4]  = mk(1,0,0,1,0, 0,32'h0C,1,32'h00,3'd4);
        tab[5]  = mk(1,0,0,0,0, 0,32'h0C,1,32'h00,3'd4);
        tab[6]  = mk(1,0,0,0,1, 1,32'h10,1,32'h04,3'd3);
        tab[7]  = mk(1,0,0,1,1, 1,32'h14,1,32'h08,3'd3);
        tab[8]  = mk(1,0,0,1,1, 1,32'h18,1,32'h0C,3'd3);
        tab[9]  = mk(1,0,0,1,1, 1,32'h1C,1,32'h10,3'd3);
        tab[10] = mk(1,0,0,1,1, 1,32'h20,1,32'h14,3'd3);
        tab[11] = mk(0,0,0,1,1, 0,32'h20,1,32'h18,3'd3);
        tab[12] = mk(0,0,0,0,1, 0,32'h20,1,32'h1C,3'd2);
        tab[13] = mk(0,0,0,0,1, 0,32'h20,1,32'h20,3'd1);
        tab[14] = mk(0,0,0,0,1, 0,32'h20,0,32'h00,3'd0);
        tab[15] = mk(1,0,0,0,1, 1,32'h24,0,32'h00,3'd0);

        do_reset("rst0");
        for (int i = 0; i < 16; i++) begin
            step($sformatf("tab%0d", i), tab[i]);
        end

        // Redirect while a delayed ack is pending: request is dropped.
        do_reset("rst1");
        step("drop0", mk(0,1,32'h10,0,0,   0,32'h00,0,32'h0,3'd0));
        step("drop1", mk(1,0,0,0,0,        1,32'h10,0,32'h0,3'd0));
        step("drop2", mk(1,1,32'h200,0,0,  1,32'h10,0,32'h0,3'd0));
        step("drop3", mk(1,0,0,0,0,        1,32'h10,0,32'h0,3'd0));
        step("drop4", mk(1,0,0,0,0,        1,32'h10,0,32'h0,3'd0));
        step("drop5", mk(1,0,0,1,0,        0,32'h10,0,32'h0,3'd0));
        step("drop6", mk(1,0,0,0,0,        1,32'h200,0,32'h0,3'd0));
        step("drop7", mk(1,0,0,1,0,        1,32'h204,1,32'h200,3'd1));

        // Redirect coinciding with an ack: response discarded.
        step("same0", mk(1,1,32'h24,0,0,   1,32'h204,0,32'h0,3'd0));
        step("same1", mk(1,0,0,1,0,        0,32'h204,0,32'h0,3'd0));
        step("same2", mk(1,0,0,0,0,        1,32'h24,0,32'h0,3'd0));
        step("same3", mk(1,1,32'h80,1,0,   0,32'h24,0,32'h0,3'd0));
        step("same4", mk(1,0,0,0,0,        1,32'h80,0,32'h0,3'd0));
        step("same5", mk(1,0,0,1,0,        1,32'h84,1,32'h80,3'd1));

        // Fetch enable dropped while a request is outstanding.
        do_reset("rst2");
        step("ce0", mk(1,0,0,0,0, 1,32'h0,0,32'h0,3'd0));
        step("ce1", mk(1,0,0,1,0, 1,32'h4,1,32'h0,3'd1));
        step("ce2", mk(1,0,0,1,0, 1,32'h8,1,32'h0,3'd2));
        step("ce3", mk(0,0,0,0,0, 1,32'h8,1,32'h0,3'd2));
        step("ce4", mk(0,0,0,1,0, 0,32'h8,1,32'h0,3'd3));
        step("ce5", mk(0,0,0,0,1, 0,32'h8,1,32'h4,3'd2));
        step("ce6", mk(0,0,0,0,1, 0,32'h8,1,32'h8,3'd1));
        step("ce7", mk(0,0,0,0,1, 0,32'h8,0,32'h0,3'd0));
        step("ce8", mk(0,0,0,0,0, 0,32'h8,0,32'h0,3'd0));
        step("ce9", mk(1,0,0,0,0, 1,32'hC,0,32'h0,3'd0));

        // Asynchronous reset with two entries queued, then a stale ack.
        step("ar0", mk(1,0,0,1,0, 1,32'h10,1,32'h0C,3'd1));
        step("ar1", mk(1,0,0,1,0, 1,32'h14,1,32'h0C,3'd2));
        #2;
        f_rst = 1'b0;
        #1;
        check_outs("ar_async", mk(0,0,0,0,0, 0,32'h0,0,32'h0,3'd0));
        f_i_ce  = 1'b0;
        f_i_ack = 1'b0;
        @(negedge f_clk);
        f_rst = 1'b1;
        step("ar2", mk(1,0,0,1,0, 1,32'h0,0,32'h0,3'd0));
        step("ar3", mk(1,0,0,1,0, 1,32'h4,1,32'h0,3'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
